// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: asynchronous serial transmitter back end.
// Accepts one byte per valid/ack handshake and sends it on txd as a frame:
// start bit, 8 data bits LSB-first, optional parity bit, then 1 or 2 stop bits.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous reset, active low
//   tx_data        byte to send, sampled only on acceptance
//   tx_data_valid  upstream request, held until tx_data_ack
//   tx_data_ack    one-cycle pulse in the first start-bit cycle
//   txd            serial line, idles high
//   busy           high from acceptance until the frame completes
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_data_ack,
  output logic       txd,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  localparam logic [15:0] BaudLast = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  StopLast = 3'(STOP_BITS - 1);

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic        txd_q, txd_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        baud_end;

  assign baud_end = (baud_q == BaudLast);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + 16'd1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    txd_d    = txd_q;
    ack_d    = 1'b0;
    busy_d   = busy_q;

    unique case (state_q)
      StIdle: begin
        baud_d = 16'd0;
        bit_d  = 3'd0;
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (tx_data_valid) begin
          shift_d  = tx_data;
          parity_d = (^tx_data) ^ PARITY_ODD;
          ack_d    = 1'b1;
          busy_d   = 1'b1;
          txd_d    = 1'b0;
          state_d  = StStart;
        end
      end

      StStart: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
          state_d = StData;
        end
      end

      StData: begin
        if (baud_end) begin
          baud_d = 16'd0;
          if (bit_q == 3'd7) begin
            bit_d = 3'd0;
            if (PARITY_EN) begin
              txd_d   = parity_q;
              state_d = StParity;
            end else begin
              txd_d   = 1'b1;
              state_d = StStop;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            // Next bit is the one that lands in position 0 after the shift.
            txd_d   = shift_q[1];
          end
        end
      end

      StParity: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          txd_d   = 1'b1;
          state_d = StStop;
        end
      end

      StStop: begin
        // bit_q counts stop bits here so two stop bits reuse the same counter.
        if (baud_end) begin
          baud_d = 16'd0;
          if (bit_q == StopLast) begin
            bit_d   = 3'd0;
            busy_d  = 1'b0;
            txd_d   = 1'b1;
            state_d = StIdle;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

      default: begin
        state_d = StIdle;
        baud_d  = 16'd0;
        bit_d   = 3'd0;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      baud_q   <= 16'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      parity_q <= 1'b0;
      txd_q    <= 1'b1;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      txd_q    <= txd_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  assign txd         = txd_q;
  assign tx_data_ack = ack_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer. Four instances with CLKS_PER_BIT=4 cover:
//   0: no parity, 1 stop; 1: even parity; 2: odd parity; 3: no parity, 2 stops.
// Expected waveforms come from a frame model: bit index -> line level.
module tb_uart_tx_serializer;

  localparam int C = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] data  [4];
  logic       valid [4];
  logic       ack   [4];
  logic       txd   [4];
  logic       busy  [4];

  int errors;
  int checks;

  // Frame configuration of each instance.
  int par_en_m [4] = '{0, 1, 1, 0};
  int odd_m    [4] = '{0, 0, 1, 0};
  int stops_m  [4] = '{1, 1, 1, 2};

  logic cap_txd  [256];
  logic cap_ack  [256];
  logic cap_busy [256];

  uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1))
    u_dut0 (.clk(clk), .rst_n(rst_n), .tx_data(data[0]), .tx_data_valid(valid[0]),
            .tx_data_ack(ack[0]), .txd(txd[0]), .busy(busy[0]));
  uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1))
    u_dut1 (.clk(clk), .rst_n(rst_n), .tx_data(data[1]), .tx_data_valid(valid[1]),
            .tx_data_ack(ack[1]), .txd(txd[1]), .busy(busy[1]));
  uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1))
    u_dut2 (.clk(clk), .rst_n(rst_n), .tx_data(data[2]), .tx_data_valid(valid[2]),
            .tx_data_ack(ack[2]), .txd(txd[2]), .busy(busy[2]));
  uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2))
    u_dut3 (.clk(clk), .rst_n(rst_n), .tx_data(data[3]), .tx_data_valid(valid[3]),
            .tx_data_ack(ack[3]), .txd(txd[3]), .busy(busy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line level of bit position idx within a frame carrying byte b on instance k.
  function automatic logic exp_bit(input int k, input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9 && par_en_m[k] != 0) return (^b) ^ logic'(odd_m[k]);
    return 1'b1;
  endfunction

  // Records outputs one step after each edge; plays the upstream side by
  // dropping valid as soon as an ack is seen.
  task automatic capture(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cap_txd[i]  = txd[k];
      cap_ack[i]  = ack[k];
      cap_busy[i] = busy[k];
      if (ack[k]) valid[k] = 1'b0;
    end
  endtask

  // Sends one byte on instance k and compares every cycle against the model.
  task automatic test_frame(input int k, input logic [7:0] b, input string name);
    int   f;
    logic e;
    f = (9 + par_en_m[k] + stops_m[k]) * C;
    data[k]  = b;
    valid[k] = 1'b1;
    capture(k, f + 3);
    for (int c = 0; c < f + 3; c++) begin
      e = (c < f) ? exp_bit(k, b, c / C) : 1'b1;
      checks++;
      if (cap_txd[c] !== e) begin
        errors++;
        $display("FAIL %s txd cyc %0d: got %b want %b", name, c, cap_txd[c], e);
      end
      checks++;
      if (cap_busy[c] !== logic'(c < f)) begin
        errors++;
        $display("FAIL %s busy cyc %0d: got %b want %b", name, c, cap_busy[c], c < f);
      end
      checks++;
      if (cap_ack[c] !== logic'(c == 0)) begin
        errors++;
        $display("FAIL %s ack cyc %0d: got %b want %b", name, c, cap_ack[c], c == 0);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid[0] = 1'b1;
    data[0]  = 8'h81;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (txd[k] !== 1'b1 || ack[k] !== 1'b0 || busy[k] !== 1'b0) begin
          errors++;
          $display("FAIL reset inst%0d cyc %0d: txd/ack/busy got %b%b%b want 100",
                   k, i, txd[k], ack[k], busy[k]);
        end
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ack[0] !== 1'b1 || busy[0] !== 1'b1 || txd[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_release ack/busy/txd got %b%b%b want 110", ack[0], busy[0], txd[0]);
    end
    valid[0] = 1'b0;
    repeat (10 * C + 2) @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int nack;
    int nbusy;
    test_frame(0, 8'h55, "single_55");
    nack  = 0;
    nbusy = 0;
    for (int c = 0; c < 43; c++) begin
      nack  += int'(cap_ack[c]);
      nbusy += int'(cap_busy[c]);
    end
    checks++;
    if (nack != 1) begin
      errors++;
      $display("FAIL single_ack_count got %0d want 1", nack);
    end
    checks++;
    if (nbusy != 40) begin
      errors++;
      $display("FAIL single_busy_len got %0d want 40", nbusy);
    end
  endtask

  task automatic test_parity();
    test_frame(1, 8'h07, "even_07");
    checks++;
    if (cap_txd[9 * C + 1] !== 1'b1) begin
      errors++;
      $display("FAIL even_parity_bit got %b want 1", cap_txd[9 * C + 1]);
    end
    test_frame(2, 8'h07, "odd_07");
    checks++;
    if (cap_txd[9 * C + 1] !== 1'b0) begin
      errors++;
      $display("FAIL odd_parity_bit got %b want 0", cap_txd[9 * C + 1]);
    end
  endtask

  task automatic test_stop2();
    int nlow;
    test_frame(3, 8'h00, "stop2_00");
    nlow = 0;
    for (int c = 0; c < 44; c++) nlow += int'(!cap_txd[c]);
    checks++;
    if (nlow != 36) begin
      errors++;
      $display("FAIL stop2_low_cycles got %0d want 36", nlow);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q [3] = '{8'hA5, 8'h3C, 8'hFF};
    int         acks [3];
    int         nack;
    int         idx;
    int         cnt;
    logic [7:0] got;
    nack = 0;
    idx  = 0;
    cnt  = 0;
    data[0]  = q[0];
    valid[0] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      cap_txd[i] = txd[0];
      if (ack[0]) begin
        if (nack < 3) acks[nack] = i;
        nack++;
        valid[0] = 1'b0;
        idx++;
        if (idx < 3) cnt = 2;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          data[0]  = q[idx];
          valid[0] = 1'b1;
        end
      end
    end
    checks++;
    if (nack != 3) begin
      errors++;
      $display("FAIL b2b_ack_count got %0d want 3", nack);
    end
    for (int n = 0; n < 3 && n < nack; n++) begin
      if (n > 0) begin
        checks++;
        if (acks[n] - acks[n-1] != 41) begin
          errors++;
          $display("FAIL b2b_spacing %0d got %0d want 41", n, acks[n] - acks[n-1]);
        end
      end
      for (int j = 0; j < 8; j++) got[j] = cap_txd[acks[n] + C * (1 + j) + C / 2];
      checks++;
      if (got !== q[n] || cap_txd[acks[n]] !== 1'b0 || cap_txd[acks[n] + 9 * C + 2] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_decode %0d got %h want %h", n, got, q[n]);
      end
    end
  endtask

  task automatic test_reset_mid();
    data[0]  = 8'hC3;
    valid[0] = 1'b1;
    // Cycle 17 after acceptance lies inside data bit 3 (a 0 for 0xC3).
    capture(0, 18);
    checks++;
    if (cap_busy[17] !== 1'b1 || cap_txd[17] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_pre busy/txd got %b%b want 10", cap_busy[17], cap_txd[17]);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (txd[0] !== 1'b1 || busy[0] !== 1'b0 || ack[0] !== 1'b0) begin
      errors++;
      $display("FAIL midreset txd/busy/ack got %b%b%b want 100", txd[0], busy[0], ack[0]);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0 || ack[0] !== 1'b0) begin
        errors++;
        $display("FAIL midreset_idle cyc %0d txd/busy/ack got %b%b%b want 100",
                 i, txd[0], busy[0], ack[0]);
      end
    end
    test_frame(0, 8'h96, "post_reset_96");
  endtask

  task automatic test_random();
    int         k;
    logic [7:0] b;
    for (int i = 0; i < 6; i++) begin
      k = int'($urandom_range(0, 3));
      b = 8'($urandom);
      test_frame(k, b, "random");
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      data[k]  = 8'h00;
      valid[k] = 1'b0;
    end
    test_reset();
    test_single();
    test_parity();
    test_stop2();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Serial-port back end that consumes the byte stream produced by the RAM-readout transmit stage.
- Accepts one byte per valid/ack handshake and shifts it out on txd as a standard asynchronous frame: start bit, 8 data bits LSB-first, optional parity bit, 1 or 2 stop bits.
- Holds off the readout stage, via the handshake, until the current frame has completed.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
- PARITY_EN, 0, 1 = insert a parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  synchronous reset, active-low.
- tx_data  input  8  byte to send; sampled only when a byte is accepted.
- tx_data_valid  input  1  upstream holds this high until it sees tx_data_ack.
- tx_data_ack  output  1  single-cycle pulse: byte accepted.
- txd  output  1  serial line; idles high.
- busy  output  1  high from byte acceptance until the frame completes.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: txd=1, tx_data_ack=0, busy=0, state=IDLE, baud counter=0, bit counter=0.
- All outputs are registered.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - txd=1, busy=0.
  - If tx_data_valid=1 at a rising edge: latch tx_data into the shift register and compute the parity bit (XOR of the 8 data bits, inverted if PARITY_ODD).
  - On that same edge: set tx_data_ack=1, busy=1, txd=0, and enter START.
- Acknowledge: tx_data_ack is high for exactly one cycle (the first START cycle); it is never asserted outside that cycle.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and is cleared on every state or bit change.
  - Each bit therefore occupies exactly CLKS_PER_BIT cycles on txd.
- START: txd=0 for CLKS_PER_BIT cycles, then enter DATA with bit index 0.
- DATA:
  - txd = shift_reg[0]; shift right at the end of each bit.
  - After bit index 7 completes, go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY: txd = parity bit for CLKS_PER_BIT cycles, then enter STOP.
- STOP:
  - txd=1 for STOP_BITS*CLKS_PER_BIT cycles, then enter IDLE.
  - busy falls on the edge that enters IDLE.
- Frame length: (10 + PARITY_EN + STOP_BITS - 1) * CLKS_PER_BIT cycles.
- Minimum frame-to-frame spacing is one extra IDLE cycle with txd=1. So for back-to-back bytes, start-bit edges are frame length + 1 cycles apart.
- Latency: valid high at edge N → txd falls and ack pulses in the cycle after edge N (zero idle-to-start delay).
- Upstream compatibility: upstream drops valid one cycle after ack and may reassert it 2 cycles later. Valid seen while busy=1 is ignored; no ack is issued and tx_data is not sampled.
- Upstream changing or dropping tx_data/valid mid-frame has no effect on the frame in progress.
- Reset asserted mid-frame: on that edge go to IDLE with txd=1 and busy=0. The byte is dropped and no further ack is issued. Reset has priority over a valid arriving on the same edge.
- Counter widths: baud counter is 16 bits; bit counter is 3 bits. Neither wraps inside a frame.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with valid=1 → txd=1, ack=0, busy=0 throughout; first ack appears 1 cycle after rst_n rises.
- Single byte 0x55, CLKS_PER_BIT=4, no parity, 1 stop → ack pulses 1 cycle; txd = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40-cycle frame); busy high 40 cycles.
- Even parity, byte 0x07 → parity bit = 1. Odd parity, byte 0x07 → parity bit = 0. Frame is 11 bits long.
- Back-to-back 0xA5, 0x3C, 0xFF, driven by a model of the readout handshake (valid drops after ack, reasserts 2 cycles later), CLKS_PER_BIT=4 → exactly 3 acks; start edges 41 cycles apart; serial data decodes to A5, 3C, FF.
- STOP_BITS=2, byte 0x00 → txd low for 9 bits (36 cycles), then high 8 cycles; frame is 44 cycles.
- Reset during DATA bit 3 → txd=1 on the next cycle, busy=0, no ack. A new valid after reset is accepted and sends a full correct frame.
